// File: rtl/key_event_pkg.sv
// key_event_pkg: shared definitions for the key event scheduler.
//   - ev_type_e   : event codes as they appear on Event_Type
//   - key_state_e : per-key hold/repeat state encoding
//   - kw()        : width of the key index, at least one bit
package key_event_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2,
    EV_REPEAT  = 2'd3
  } ev_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } key_state_e;

  function automatic int kw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_event_fsm.sv
// key_event_fsm: one key's press/hold/repeat state machine, its tick counter
// and the one-deep pending event slot that feeds the arbiter.
// Ports:
//   Clk, Reset  : clock, synchronous active-high reset
//   key_i       : registered key level (1 = pressed)
//   tick_i      : one-cycle millisecond strobe from the shared prescaler
//   grant_i     : arbiter takes this key's pending event this cycle
//   pend_o      : pending slot holds an event
//   type_o      : type of the pending event
//   overflow_o  : a pending, ungranted event is being overwritten this cycle
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int HOLD_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       key_i,
  input  logic       tick_i,
  input  logic       grant_i,
  output logic       pend_o,
  output logic [1:0] type_o,
  output logic       overflow_o
);

  localparam int CMAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_MS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'((REPEAT_MS == 0) ? 0 : REPEAT_MS - 1);
  localparam bit REPEAT_EN = (REPEAT_MS != 0);

  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  ev_type_e      type_q, type_d;
  logic          emit;
  ev_type_e      emit_type;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_type = EV_PRESS;
    case (state_q)
      ST_IDLE: begin
        if (key_i) begin
          emit      = 1'b1;
          emit_type = EV_PRESS;
          cnt_d     = '0;
          state_d   = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        // Release is checked first so it wins over a timer event.
        if (!key_i) begin
          emit      = 1'b1;
          emit_type = EV_RELEASE;
          state_d   = ST_IDLE;
        end else if (tick_i) begin
          if (cnt_q == HOLD_LAST) begin
            emit      = 1'b1;
            emit_type = EV_LONG;
            cnt_d     = '0;
            state_d   = ST_HELD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_HELD: begin
        if (!key_i) begin
          emit      = 1'b1;
          emit_type = EV_RELEASE;
          state_d   = ST_IDLE;
        end else if (REPEAT_EN && tick_i) begin
          if (cnt_q == REPEAT_LAST) begin
            emit      = 1'b1;
            emit_type = EV_REPEAT;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A grant empties the slot; a new event in the same cycle refills it.
  // Only an event landing on a full, ungranted slot loses data.
  always_comb begin
    pend_d = pend_q & ~grant_i;
    type_d = type_q;
    if (emit) begin
      pend_d = 1'b1;
      type_d = emit_type;
    end
  end

  assign overflow_o = emit & pend_q & ~grant_i;
  assign pend_o     = pend_q;
  assign type_o     = type_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      type_q  <= EV_PRESS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      type_q  <= type_d;
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: converts N debounced key levels into a serial stream
// of PRESS / RELEASE / LONG / REPEAT events on a valid/ready port.
// Ports:
//   Clk, Reset   : clock, synchronous active-high reset
//   Keys         : debounced key levels, 1 = pressed
//   Event_Valid  : output register holds an event
//   Event_Ready  : consumer accepts the event when high with Event_Valid
//   Event_Key    : index of the key that produced the event
//   Event_Type   : 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   Overflow     : one-cycle pulse when a pending event was overwritten
module key_event_scheduler
  import key_event_pkg::*;
#(
  parameter int N         = 4,
  parameter int TICK      = 50000,
  parameter int HOLD_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [N-1:0]       Keys,
  output logic               Event_Valid,
  input  logic               Event_Ready,
  output logic [kw(N)-1:0]   Event_Key,
  output logic [1:0]         Event_Type,
  output logic               Overflow
);

  localparam int KW  = kw(N);
  localparam int CW2 = KW + 1;
  localparam int PW  = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK - 1);

  logic [N-1:0]   keys_1_q;
  logic [PW-1:0]  presc_q, presc_d;
  logic           tick;
  logic [N-1:0]   pend;
  logic [N-1:0]   grant;
  logic [N-1:0]   key_ovf;
  logic [1:0]     ptype [N];
  logic           valid_q, valid_d;
  logic [KW-1:0]  key_q, key_d;
  logic [KW-1:0]  last_q, last_d;
  logic [1:0]     type_q, type_d;
  logic           ovf_q;
  logic           load;
  logic           found;
  logic [KW-1:0]  gnt_idx;
  logic [CW2-1:0] cand;

  // Shared millisecond prescaler.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_key
    key_event_fsm #(
      .HOLD_MS  (HOLD_MS),
      .REPEAT_MS(REPEAT_MS)
    ) u_fsm (
      .Clk       (Clk),
      .Reset     (Reset),
      .key_i     (keys_1_q[gi]),
      .tick_i    (tick),
      .grant_i   (grant[gi]),
      .pend_o    (pend[gi]),
      .type_o    (ptype[gi]),
      .overflow_o(key_ovf[gi])
    );
  end

  // Round-robin search starting one past the last granted key. The
  // candidate index is last+k with k in 1..N, so one subtraction wraps it.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + CW2'(k);
      if (cand >= CW2'(N)) begin
        cand = cand - CW2'(N);
      end
      if (!found && pend[cand[KW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[KW-1:0];
      end
    end
  end

  // Output register: refills whenever it is empty or being consumed, so
  // Key/Type stay frozen while a presented event is stalled.
  always_comb begin
    load    = ~valid_q | Event_Ready;
    valid_d = valid_q;
    key_d   = key_q;
    type_d  = type_q;
    last_d  = last_q;
    grant   = '0;
    if (load) begin
      valid_d = found;
      if (found) begin
        key_d          = gnt_idx;
        type_d         = ptype[gnt_idx];
        last_d         = gnt_idx;
        grant[gnt_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      keys_1_q <= '0;
      presc_q  <= '0;
      valid_q  <= 1'b0;
      key_q    <= '0;
      type_q   <= EV_PRESS;
      last_q   <= KW'(N - 1);
      ovf_q    <= 1'b0;
    end else begin
      keys_1_q <= Keys;
      presc_q  <= presc_d;
      valid_q  <= valid_d;
      key_q    <= key_d;
      type_q   <= type_d;
      last_q   <= last_d;
      ovf_q    <= |key_ovf;
    end
  end

  assign Event_Valid = valid_q;
  assign Event_Key   = key_q;
  assign Event_Type  = type_q;
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
module tb_key_event_scheduler;

  localparam int N = 4, TICK = 10, HOLD = 5, REP = 3;
  localparam int PRESS = 0, RELEASE = 1, LONG = 2, REPEAT = 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keys  = '0;
  logic       ready = 1'b1;
  logic       ev_valid;
  logic [1:0] ev_key, ev_type;
  logic       ev_ovf;

  logic [3:0] keys0 = '0;
  logic       v0, o0;
  logic [1:0] k0, t0;

  always #5 clk = ~clk;

  key_event_scheduler #(.N(N), .TICK(TICK), .HOLD_MS(HOLD), .REPEAT_MS(REP)) dut (
    .Clk(clk), .Reset(reset), .Keys(keys), .Event_Valid(ev_valid), .Event_Ready(ready),
    .Event_Key(ev_key), .Event_Type(ev_type), .Overflow(ev_ovf));

  key_event_scheduler #(.N(N), .TICK(TICK), .HOLD_MS(HOLD), .REPEAT_MS(0)) dut0 (
    .Clk(clk), .Reset(reset), .Keys(keys0), .Event_Valid(v0), .Event_Ready(1'b1),
    .Event_Key(k0), .Event_Type(t0), .Overflow(o0));

  int checks = 0, failures = 0, cyc = 0, ovf_seen = 0;
  typedef struct { int key; int typ; int t; } evt_t;
  evt_t log_q[$];

  // Reference model state: held flag plus ticks elapsed since the press.
  logic [3:0] m_k1;
  int  m_presc, m_key, m_type, m_last;
  bit  m_valid, m_ovf;
  bit  m_held [4];
  int  m_ticks [4];
  bit  m_pend [4];
  int  m_ptype [4];

  // REPEAT_MS=0 instance monitor (Ready tied high: one event per valid cycle).
  int n_press0 = 0, n_long0 = 0, n_rep0 = 0, n_other0 = 0, n_ovf0 = 0;
  always @(negedge clk) begin
    if (reset === 1'b0 && v0 === 1'b1) begin
      if (k0 != 2'd0) n_other0++;
      else if (t0 == 2'd0) n_press0++;
      else if (t0 == 2'd2) n_long0++;
      else if (t0 == 2'd3) n_rep0++;
      else n_other0++;
    end
    if (reset === 1'b0 && o0 === 1'b1) n_ovf0++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] k, input logic r, input logic rst);
    bit tick, load;
    int g, idx, ev;
    if (rst) begin
      m_k1 = '0; m_presc = 0; m_valid = 0; m_key = 0; m_type = 0; m_last = N - 1; m_ovf = 0;
      for (int i = 0; i < N; i++) begin
        m_held[i] = 0; m_ticks[i] = 0; m_pend[i] = 0; m_ptype[i] = 0;
      end
    end else begin
      tick = (m_presc == TICK - 1);
      load = !m_valid || r;
      g = -1;
      if (load) begin
        for (int j = 1; j <= N; j++) begin
          idx = (m_last + j) % N;
          if (g < 0 && m_pend[idx]) g = idx;
        end
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_key = g; m_type = m_ptype[g]; m_last = g; m_pend[g] = 0;
        end
      end
      m_ovf = 0;
      for (int i = 0; i < N; i++) begin
        ev = -1;
        if (!m_held[i]) begin
          if (m_k1[i]) begin ev = PRESS; m_held[i] = 1; m_ticks[i] = 0; end
        end else if (!m_k1[i]) begin
          ev = RELEASE; m_held[i] = 0;
        end else if (tick) begin
          m_ticks[i]++;
          if (m_ticks[i] == HOLD) ev = LONG;
          else if (REP != 0 && m_ticks[i] > HOLD && (m_ticks[i] - HOLD) % REP == 0) ev = REPEAT;
        end
        if (ev >= 0) begin
          if (m_pend[i]) m_ovf = 1;
          m_pend[i] = 1; m_ptype[i] = ev;
        end
      end
      m_presc = tick ? 0 : m_presc + 1;
      m_k1 = k;
    end
  endtask

  task automatic cycle(input logic [3:0] k, input logic r, input logic rst);
    if (ev_valid === 1'b1 && r && !rst) begin
      log_q.push_back('{key: int'(ev_key), typ: int'(ev_type), t: cyc});
      $display("EVT cyc=%0d key=%0d type=%0d", cyc, ev_key, ev_type);
    end
    keys = k; ready = r; reset = rst;
    @(posedge clk);
    model_step(k, r, rst);
    cyc++;
    #1;
    if (ev_ovf === 1'b1) ovf_seen++;
    chk("model_valid", ev_valid, m_valid);
    chk("model_key", ev_key, m_key);
    chk("model_type", ev_type, m_type);
    chk("model_ovf", ev_ovf, m_ovf);
  endtask

  task automatic do_reset();
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1);
  endtask

  typedef struct {
    logic [3:0] keys; logic ready; logic rst;
    logic valid; logic [1:0] key; logic [1:0] typ; logic ovf;
  } vec_t;
  vec_t vt [14];

  initial begin
    int c0, n, lp_found;
    logic [3:0] cur;
    logic r, rs;

    // Reset, simultaneous press of keys 0/1/3, then simultaneous release.
    vt[0]  = '{4'b0000, 1, 1, 0, 0, 0, 0};
    vt[1]  = '{4'b0000, 1, 1, 0, 0, 0, 0};
    vt[2]  = '{4'b1011, 1, 0, 0, 0, 0, 0};
    vt[3]  = '{4'b1011, 1, 0, 0, 0, 0, 0};
    vt[4]  = '{4'b1011, 1, 0, 1, 0, 0, 0};
    vt[5]  = '{4'b1011, 1, 0, 1, 1, 0, 0};
    vt[6]  = '{4'b1011, 1, 0, 1, 3, 0, 0};
    vt[7]  = '{4'b1011, 1, 0, 0, 3, 0, 0};
    vt[8]  = '{4'b0000, 1, 0, 0, 3, 0, 0};
    vt[9]  = '{4'b0000, 1, 0, 0, 3, 0, 0};
    vt[10] = '{4'b0000, 1, 0, 1, 0, 1, 0};
    vt[11] = '{4'b0000, 1, 0, 1, 1, 1, 0};
    vt[12] = '{4'b0000, 1, 0, 1, 3, 1, 0};
    vt[13] = '{4'b0000, 1, 0, 0, 3, 1, 0};
    for (int i = 0; i < 14; i++) begin
      cycle(vt[i].keys, vt[i].ready, vt[i].rst);
      chk($sformatf("vec%0d_valid", i), ev_valid, vt[i].valid);
      chk($sformatf("vec%0d_key", i), ev_key, vt[i].key);
      chk($sformatf("vec%0d_type", i), ev_type, vt[i].typ);
      chk($sformatf("vec%0d_ovf", i), ev_ovf, vt[i].ovf);
    end

    // Hold key 2: PRESS latency, LONG delay, REPEAT spacing.
    do_reset();
    log_q.delete();
    c0 = cyc;
    for (int i = 0; i < 151; i++) cycle(4'b0100, 1'b1, 1'b0);
    chk("s1_nevents_ge4", log_q.size() >= 4, 1);
    if (log_q.size() >= 4) begin
      chk("s1_press_key", log_q[0].key, 2);
      chk("s1_press_type", log_q[0].typ, PRESS);
      chk("s1_press_latency", log_q[0].t, c0 + 3);
      chk("s1_long_key", log_q[1].key, 2);
      chk("s1_long_type", log_q[1].typ, LONG);
      chk("s1_long_delay_in_window",
          (log_q[1].t - log_q[0].t >= 40) && (log_q[1].t - log_q[0].t <= 60), 1);
      chk("s1_rep1_type", log_q[2].typ, REPEAT);
      chk("s1_rep1_gap", log_q[2].t - log_q[1].t, 30);
      chk("s1_rep2_type", log_q[3].typ, REPEAT);
      chk("s1_rep2_gap", log_q[3].t - log_q[2].t, 30);
    end

    // Release so that Keys_1 drops on the very tick a REPEAT would be due.
    lp_found = 0;
    for (int i = 0; i < 100 && lp_found == 0; i++) begin
      if (m_presc == TICK - 2 && m_ticks[2] >= HOLD && ((m_ticks[2] + 1 - HOLD) % REP) == 0)
        lp_found = 1;
      else
        cycle(4'b0100, 1'b1, 1'b0);
    end
    chk("s1b_release_point_found", lp_found, 1);
    n = log_q.size();
    for (int i = 0; i < 40; i++) cycle(4'b0000, 1'b1, 1'b0);
    chk("s1b_single_event", log_q.size() - n, 1);
    if (log_q.size() > n) begin
      chk("s1b_release_type", log_q[n].typ, RELEASE);
      chk("s1b_release_key", log_q[n].key, 2);
    end

    // Stalled consumer: PRESS/0 stays presented, key 1 slot overflows once.
    do_reset();
    log_q.delete();
    ovf_seen = 0;
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'b0001, 1'b0, 1'b0);
    chk("s3_stall_valid", ev_valid, 1);
    chk("s3_stall_key", ev_key, 0);
    chk("s3_stall_type", ev_type, PRESS);
    chk("s3_overflow_pulses", ovf_seen, 1);
    for (int i = 0; i < 6; i++) cycle(4'b0001, 1'b1, 1'b0);
    chk("s3_nevents", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("s3_ev0_key", log_q[0].key, 0);
      chk("s3_ev0_type", log_q[0].typ, PRESS);
      chk("s3_ev1_key", log_q[1].key, 1);
      chk("s3_ev1_type", log_q[1].typ, RELEASE);
    end

    // Reset pulse while key 3 is HELD with events pending.
    do_reset();
    for (int i = 0; i < 70; i++) cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b1);
    chk("s4_reset_valid", ev_valid, 0);
    log_q.delete();
    c0 = cyc;
    for (int i = 0; i < 80; i++) cycle(4'b1000, 1'b1, 1'b0);
    chk("s4_nevents_ge2", log_q.size() >= 2, 1);
    if (log_q.size() >= 2) begin
      chk("s4_press_key", log_q[0].key, 3);
      chk("s4_press_type", log_q[0].typ, PRESS);
      chk("s4_press_latency", log_q[0].t, c0 + 3);
      chk("s4_long_type", log_q[1].typ, LONG);
      chk("s4_long_delay_in_window",
          (log_q[1].t - log_q[0].t >= 40) && (log_q[1].t - log_q[0].t <= 60), 1);
    end

    // Randomized keys / ready / rare reset against the reference model.
    do_reset();
    cur = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 31) == 0) cur[b] = ~cur[b];
      r  = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 499) == 0);
      cycle(cur, r, rs);
    end

    // REPEAT_MS = 0 build: hold key 0 for 200 cycles.
    do_reset();
    keys0 = 4'b0001;
    for (int i = 0; i < 200; i++) cycle(4'b0000, 1'b1, 1'b0);
    chk("s5_press_count", n_press0, 1);
    chk("s5_long_count", n_long0, 1);
    chk("s5_repeat_count", n_rep0, 0);
    chk("s5_other_count", n_other0, 0);
    chk("s5_overflow_count", n_ovf0, 0);
    keys0 = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
